// File: rtl/pixel_barycentric_gen_if.sv
// Request/result bundle between the triangle feeder and the barycentric
// generator: ready/data_valid request side, calc_done/read_done result side.
interface pixel_barycentric_gen_if;
  logic               ready;
  logic               data_valid;
  logic               calc_done;
  logic               read_done;
  logic signed [15:0] vertex_x [3];
  logic signed [15:0] vertex_y [3];
  logic signed [15:0] pixel_x;
  logic signed [15:0] pixel_y;
  logic [31:0]        barycentric_coords [3];
  logic               pixel_inside;
  logic               degenerate;
  logic signed [15:0] out_pixel_x;
  logic signed [15:0] out_pixel_y;

  modport master (
    input  ready, calc_done, barycentric_coords,
    input  pixel_inside, degenerate,
    input  out_pixel_x, out_pixel_y,
    output data_valid, read_done,
    output vertex_x, vertex_y, pixel_x, pixel_y
  );

  modport slave (
    output ready, calc_done, barycentric_coords,
    output pixel_inside, degenerate,
    output out_pixel_x, out_pixel_y,
    input  data_valid, read_done,
    input  vertex_x, vertex_y, pixel_x, pixel_y
  );
endinterface

// File: rtl/pixel_barycentric_gen.sv
// Edge functions, inside test and Q1.31 barycentric normalization
// for one pixel against one screen-space triangle.
module pixel_barycentric_gen #(
  parameter bit CULL_BACKFACE = 1'b0,
  parameter int DIV_BITS      = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  pixel_barycentric_gen_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_EDGE,
    S_CLASSIFY,
    S_DIVIDE,
    S_OUTPUT,
    S_WAIT
  } state_e;

  localparam int BW = $clog2(DIV_BITS + 1);

  state_e               state_q, state_d;
  logic [1:0]           step_q, step_d;
  logic [1:0]           idx_q, idx_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic signed [15:0]   vx_q [3];
  logic signed [15:0]   vx_d [3];
  logic signed [15:0]   vy_q [3];
  logic signed [15:0]   vy_d [3];
  logic signed [15:0]   px_q, px_d;
  logic signed [15:0]   py_q, py_d;
  logic signed [34:0]   area_q, area_d;
  logic signed [34:0]   e_q [3];
  logic signed [34:0]   e_d [3];
  logic [35:0]          rem_q, rem_d;
  logic [31:0]          quo_q, quo_d;
  logic [31:0]          bary_q [3];
  logic [31:0]          bary_d [3];
  logic                 inside_q, inside_d;
  logic                 degen_q, degen_d;

  logic signed [15:0]   ax, ay, bx, by, qx, qy;
  logic signed [16:0]   dx_ab, dy_aq, dy_ab, dx_aq;
  logic signed [33:0]   m0, m1;
  logic signed [34:0]   ev;

  // One edge function per cycle: step 0 is the area, 1..3 are e0..e2
  always_comb begin
    ax = vx_q[0];
    ay = vy_q[0];
    bx = vx_q[1];
    by = vy_q[1];
    qx = vx_q[2];
    qy = vy_q[2];
    unique case (step_q)
      2'd0: begin
        ax = vx_q[0]; ay = vy_q[0];
        bx = vx_q[1]; by = vy_q[1];
        qx = vx_q[2]; qy = vy_q[2];
      end
      2'd1: begin
        ax = vx_q[1]; ay = vy_q[1];
        bx = vx_q[2]; by = vy_q[2];
        qx = px_q;    qy = py_q;
      end
      2'd2: begin
        ax = vx_q[2]; ay = vy_q[2];
        bx = vx_q[0]; by = vy_q[0];
        qx = px_q;    qy = py_q;
      end
      default: begin
        ax = vx_q[0]; ay = vy_q[0];
        bx = vx_q[1]; by = vy_q[1];
        qx = px_q;    qy = py_q;
      end
    endcase
    dx_ab = 17'(bx) - 17'(ax);
    dy_aq = 17'(qy) - 17'(ay);
    dy_ab = 17'(by) - 17'(ay);
    dx_aq = 17'(qx) - 17'(ax);
    m0    = 34'(dx_ab) * 34'(dy_aq);
    m1    = 34'(dy_ab) * 34'(dx_aq);
    ev    = 35'(m0) - 35'(m1);
  end

  logic        neg;
  logic        div_ge;
  logic [35:0] area_u;
  logic [35:0] rem_sub;
  logic [31:0] quo_next;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    idx_d    = idx_q;
    bit_d    = bit_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    px_d     = px_q;
    py_d     = py_q;
    area_d   = area_q;
    e_d      = e_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    bary_d   = bary_q;
    inside_d = inside_q;
    degen_d  = degen_q;
    neg      = area_q[34];
    area_u   = {1'b0, area_q};
    div_ge   = rem_q >= area_u;
    rem_sub  = div_ge ? rem_q - area_u : rem_q;
    quo_next = {quo_q[30:0], div_ge};

    unique case (state_q)
      S_IDLE: begin
        if (bus.data_valid) begin
          vx_d    = bus.vertex_x;
          vy_d    = bus.vertex_y;
          px_d    = bus.pixel_x;
          py_d    = bus.pixel_y;
          step_d  = 2'd0;
          state_d = S_EDGE;
        end
      end
      S_EDGE: begin
        if (step_q == 2'd0) area_d = ev;
        else e_d[step_q - 2'd1] = ev;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = S_CLASSIFY;
      end
      S_CLASSIFY: begin
        if (neg && !CULL_BACKFACE) begin
          area_d = -area_q;
          for (int i = 0; i < 3; i++) e_d[i] = -e_q[i];
        end
        degen_d  = (area_q == '0);
        inside_d = !degen_d && !(neg && CULL_BACKFACE)
                   && !e_d[0][34] && !e_d[1][34] && !e_d[2][34];
        bary_d   = '{default: '0};
        if (inside_d) begin
          rem_d   = {1'b0, e_d[0]};
          quo_d   = '0;
          idx_d   = 2'd0;
          bit_d   = '0;
          state_d = S_DIVIDE;
        end else begin
          state_d = S_OUTPUT;
        end
      end
      S_DIVIDE: begin
        // rem_sub < area, so the doubled remainder always fits
        rem_d = rem_sub << 1;
        quo_d = quo_next;
        bit_d = bit_q + BW'(1);
        if (bit_q == BW'(DIV_BITS - 1)) begin
          bary_d[idx_q] = quo_next << (32 - DIV_BITS);
          bit_d = '0;
          quo_d = '0;
          if (idx_q == 2'd2) begin
            state_d = S_OUTPUT;
          end else begin
            idx_d = idx_q + 2'd1;
            rem_d = {1'b0, e_q[idx_q + 2'd1]};
          end
        end
      end
      S_OUTPUT: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.read_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      idx_q    <= '0;
      bit_q    <= '0;
      px_q     <= '0;
      py_q     <= '0;
      area_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      inside_q <= 1'b0;
      degen_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        vx_q[i]   <= '0;
        vy_q[i]   <= '0;
        e_q[i]    <= '0;
        bary_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      idx_q    <= idx_d;
      bit_q    <= bit_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      px_q     <= px_d;
      py_q     <= py_d;
      area_q   <= area_d;
      e_q      <= e_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      bary_q   <= bary_d;
      inside_q <= inside_d;
      degen_q  <= degen_d;
    end
  end

  assign bus.ready              = (state_q == S_IDLE);
  assign bus.calc_done          = (state_q == S_OUTPUT);
  assign bus.barycentric_coords = bary_q;
  assign bus.pixel_inside       = inside_q;
  assign bus.degenerate         = degen_q;
  assign bus.out_pixel_x        = px_q;
  assign bus.out_pixel_y        = py_q;
endmodule

// File: tb/tb_pixel_barycentric_gen.sv
// Scoreboard bench: two instances (winding accepted / backface culled)
// driven with identical directed triangles and pixels.
module tb_pixel_barycentric_gen;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pixel_barycentric_gen_if bus_a ();
  pixel_barycentric_gen_if bus_b ();

  pixel_barycentric_gen #(.CULL_BACKFACE(1'b0), .DIV_BITS(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  pixel_barycentric_gen #(.CULL_BACKFACE(1'b1), .DIV_BITS(32)) u_cull (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    string       name;
    logic [31:0] w0, w1, w2;
    logic        ins;
    logic        dg;
    int          lat;
    int          acc;
    logic [15:0] px, py;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ma, mb;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done_a = 0;
  int   n_done_b = 0;
  int   issued  = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  function automatic exp_t mk(string name, logic [31:0] w0, w1, w2,
                              logic ins, logic dg);
    exp_t e;
    e.name = name;
    e.w0 = w0; e.w1 = w1; e.w2 = w2;
    e.ins = ins; e.dg = dg;
    e.lat = ins ? 102 : 6;
    e.acc = 0; e.px = '0; e.py = '0;
    return e;
  endfunction

  function automatic void cmp(string tag, exp_t e, logic [31:0] w0, w1, w2,
                              logic ins, logic dg, logic [15:0] ox, oy);
    chk({tag, "_u"}, w0, e.w0);
    chk({tag, "_v"}, w1, e.w1);
    chk({tag, "_w"}, w2, e.w2);
    chk({tag, "_inside"}, ins, e.ins);
    chk({tag, "_degen"}, dg, e.dg);
    chk({tag, "_pix"}, {ox, oy}, {e.px, e.py});
    chk({tag, "_latency"}, cyc - e.acc + 1, e.lat);
  endfunction

  // Monitor: pop and compare whenever either instance signals calc_done
  always @(negedge clk) begin
    if (bus_a.calc_done) begin
      if (q_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_stray_done: calc_done=1, required 0");
      end else begin
        ma = q_a.pop_front();
        cmp({"a_", ma.name}, ma, bus_a.barycentric_coords[0],
            bus_a.barycentric_coords[1], bus_a.barycentric_coords[2],
            bus_a.pixel_inside, bus_a.degenerate,
            bus_a.out_pixel_x, bus_a.out_pixel_y);
        n_done_a++;
      end
    end
    if (bus_b.calc_done) begin
      if (q_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_stray_done: calc_done=1, required 0");
      end else begin
        mb = q_b.pop_front();
        cmp({"b_", mb.name}, mb, bus_b.barycentric_coords[0],
            bus_b.barycentric_coords[1], bus_b.barycentric_coords[2],
            bus_b.pixel_inside, bus_b.degenerate,
            bus_b.out_pixel_x, bus_b.out_pixel_y);
        n_done_b++;
      end
    end
  end

  task automatic drive(input logic signed [15:0] x0, y0, x1, y1, x2, y2,
                       input logic signed [15:0] px, py, input logic dv);
    bus_a.vertex_x[0] = x0; bus_a.vertex_y[0] = y0;
    bus_a.vertex_x[1] = x1; bus_a.vertex_y[1] = y1;
    bus_a.vertex_x[2] = x2; bus_a.vertex_y[2] = y2;
    bus_a.pixel_x = px; bus_a.pixel_y = py;
    bus_b.vertex_x = bus_a.vertex_x;
    bus_b.vertex_y = bus_a.vertex_y;
    bus_b.pixel_x = px; bus_b.pixel_y = py;
    bus_a.data_valid = dv;
    bus_b.data_valid = dv;
  endtask

  task automatic wait_ready(string tag);
    int t;
    t = 0;
    while (!(bus_a.ready && bus_b.ready) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ready_in"}, {bus_a.ready, bus_b.ready}, 2'b11);
  endtask

  task automatic run(string tag,
                     input logic signed [15:0] x0, y0, x1, y1, x2, y2,
                     input logic signed [15:0] px, py,
                     input exp_t ea, input exp_t eb,
                     input int hold, input bit poke);
    int t;
    int bad;
    wait_ready(tag);
    drive(x0, y0, x1, y1, x2, y2, px, py, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(x0, y0, x1, y1, x2, y2, px, py, 1'b0);
    ea.acc = cyc; eb.acc = cyc;
    ea.px = px; ea.py = py;
    eb.px = px; eb.py = py;
    q_a.push_back(ea);
    q_b.push_back(eb);
    issued++;
    if (poke) begin
      repeat (40) @(negedge clk);
      drive(-16'sd5, 16'sd7, 16'sd100, 16'sd3, 16'sd1, 16'sd90,
            16'sd11, 16'sd12, 1'b1);
      @(negedge clk);
      drive(x0, y0, x1, y1, x2, y2, px, py, 1'b0);
    end
    t = 0;
    while ((n_done_a < issued || n_done_b < issued) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done_in_time"}, t < 300, 1'b1);
    bad = 0;
    repeat (hold) begin
      @(negedge clk);
      if (bus_a.ready !== 1'b0 || bus_b.ready !== 1'b0) bad++;
      if (bus_a.calc_done !== 1'b0 || bus_b.calc_done !== 1'b0) bad++;
      if (bus_a.barycentric_coords[0] !== ea.w0) bad++;
      if (bus_a.barycentric_coords[1] !== ea.w1) bad++;
      if (bus_a.barycentric_coords[2] !== ea.w2) bad++;
      if (bus_a.pixel_inside !== ea.ins) bad++;
      if (bus_b.barycentric_coords[0] !== eb.w0) bad++;
      if (bus_b.pixel_inside !== eb.ins) bad++;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, bad, 0);
    bus_a.read_done = 1'b1;
    bus_b.read_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_a.read_done = 1'b0;
    bus_b.read_done = 1'b0;
    chk({tag, "_ready_after_read"}, {bus_a.ready, bus_b.ready}, 2'b11);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ready"}, {bus_a.ready, bus_b.ready}, 2'b11);
    chk({tag, "_calc_done"}, {bus_a.calc_done, bus_b.calc_done}, 2'b00);
    chk({tag, "_weights_a"}, {bus_a.barycentric_coords[0],
        bus_a.barycentric_coords[1]} | 64'(bus_a.barycentric_coords[2]), 64'd0);
    chk({tag, "_weights_b"}, {bus_b.barycentric_coords[0],
        bus_b.barycentric_coords[1]} | 64'(bus_b.barycentric_coords[2]), 64'd0);
    chk({tag, "_flags"}, {bus_a.pixel_inside, bus_a.degenerate,
        bus_b.pixel_inside, bus_b.degenerate}, 4'b0000);
    chk({tag, "_pix"}, {bus_a.out_pixel_x, bus_a.out_pixel_y,
        bus_b.out_pixel_x, bus_b.out_pixel_y}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    exp_t e_in, e_out;
    rst_n = 1'b0;
    bus_a.read_done = 1'b0;
    bus_b.read_done = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    e_in = mk("basic", 32'h4000_0000, 32'h2000_0000, 32'h2000_0000, 1, 0);
    run("basic", 0, 0, 8, 0, 0, 8, 2, 2, e_in, e_in, 20, 0);
    e_in = mk("vertex", 32'h8000_0000, 0, 0, 1, 0);
    run("vertex", 0, 0, 8, 0, 0, 8, 0, 0, e_in, e_in, 2, 0);
    e_in = mk("on_edge", 32'h4000_0000, 32'h4000_0000, 0, 1, 0);
    run("on_edge", 0, 0, 8, 0, 0, 8, 4, 0, e_in, e_in, 2, 1);
    e_out = mk("outside", 0, 0, 0, 0, 0);
    run("outside", 0, 0, 8, 0, 0, 8, 9, 9, e_out, e_out, 2, 0);
    e_in  = mk("cw", 32'h4000_0000, 32'h2000_0000, 32'h2000_0000, 1, 0);
    e_out = mk("cw", 0, 0, 0, 0, 0);
    run("cw", 0, 0, 0, 8, 8, 0, 2, 2, e_in, e_out, 2, 0);
    e_out = mk("degen", 0, 0, 0, 0, 1);
    run("degen", 0, 0, 4, 4, 8, 8, 1, 1, e_out, e_out, 2, 0);
    e_in = mk("thirds", 32'h2AAA_AAAA, 32'h2AAA_AAAA, 32'h2AAA_AAAA, 1, 0);
    run("thirds", 0, 0, 3, 0, 0, 3, 1, 1, e_in, e_in, 2, 0);
    e_in = mk("negcoord", 0, 32'h4000_0000, 32'h4000_0000, 1, 0);
    run("negcoord", -10, -10, 10, -10, -10, 10, 0, 0, e_in, e_in, 2, 0);
    e_in = mk("extreme", 32'h8000_0000, 0, 0, 1, 0);
    run("extreme", -32768, -32768, 32767, -32768, -32768, 32767,
        -32768, -32768, e_in, e_in, 2, 0);

    // Abandon a request mid-divide; nothing may complete afterwards
    wait_ready("abort");
    drive(0, 0, 8, 0, 0, 8, 2, 2, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 8, 0, 0, 8, 2, 2, 1'b0);
    acc = cyc;
    while (cyc - acc < 49) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("abort");
    rst_n = 1'b1;
    repeat (110) @(negedge clk);

    e_in = mk("after_abort", 32'h4000_0000, 32'h2000_0000, 32'h2000_0000, 1, 0);
    run("after_abort", 0, 0, 8, 0, 0, 8, 2, 2, e_in, e_in, 2, 0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
